// File: rtl/fir_sched_pkg.sv
// Shared types and width helpers for the FIR stream scheduler.
// The state encoding is fixed here so that every file sees the same values.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        StFlush = 2'd0,
        StIdle  = 2'd1,
        StGrant = 2'd2
    } state_e;

    // clog2 that never returns less than one bit, so single-value fields stay legal
    function automatic int unsigned cw_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_stream_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// from (ptr+1) mod N with wrap-around.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = cw_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned    j;
    logic [IW-1:0]  j_idx;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            j     = (32'(ptr) + i) % N;
            j_idx = IW'(j);
            if (!any && req[j_idx]) begin
                any        = 1'b1;
                gnt[j_idx] = 1'b1;
                idx        = j_idx;
            end
        end
    end

endmodule

// File: rtl/fir_stream_scheduler.sv
// Time-shares one clock-enabled FIR datapath between NCH packet streams, granting a
// whole packet at a time and flushing the delay line with zeros before the next owner.
module fir_stream_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned WL   = 32,
    parameter int unsigned NCH  = 4,
    parameter int unsigned TAPS = 8,
    parameter int unsigned LAT  = 1,
    localparam int unsigned CW  = cw_of(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH-1:0]    req_last,
    input  logic [NCH*WL-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    output logic [WL-1:0]     fir_xin,
    output logic              fir_ce,
    input  logic [WL-1:0]     fir_yout,
    output logic              out_valid,
    output logic [WL-1:0]     out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned    FW        = cw_of(TAPS);
    localparam logic [FW-1:0]  FlushInit = FW'(TAPS - 2);
    localparam logic [CW-1:0]  PtrInit   = CW'(NCH - 1);

    state_e          state_q, state_d;
    logic [FW-1:0]   cnt_q, cnt_d;
    // Owner doubles as the round-robin pointer: both always equal the last grantee.
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [NCH-1:0]  owner_oh_q, owner_oh_d;
    logic [WL-1:0]   xin_q, xin_d;
    logic            ce_q, ce_d;

    logic [NCH-1:0]  arb_gnt;
    logic [CW-1:0]   arb_idx;
    logic            arb_any;

    logic            hs;
    logic            sel_last;
    logic [WL-1:0]   sel_data;

    // Stage 0 is aligned with fir_xin; stage LAT is aligned with fir_yout.
    logic [LAT:0]    tv_q, tv_d;
    logic [LAT:0]    tl_q, tl_d;
    logic [CW-1:0]   tch_q [LAT+1];
    logic [CW-1:0]   tch_d [LAT+1];

    rr_arbiter #(
        .N (NCH)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign req_ready = (state_q == StGrant) ? owner_oh_q : '0;
    assign hs        = |(req_valid & req_ready);
    assign sel_last  = req_last[ptr_q];
    assign sel_data  = req_data[ptr_q*WL +: WL];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        owner_oh_d = owner_oh_q;
        xin_d      = '0;
        ce_d       = 1'b0;
        unique case (state_q)
            StFlush: begin
                ce_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StIdle: begin
                if (arb_any) begin
                    ptr_d      = arb_idx;
                    owner_oh_d = arb_gnt;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (hs) begin
                    xin_d = sel_data;
                    ce_d  = 1'b1;
                    if (sel_last) begin
                        state_d = StFlush;
                        cnt_d   = FlushInit;
                    end
                end
            end
            default: begin
                state_d = StFlush;
                cnt_d   = FlushInit;
            end
        endcase
    end

    always_comb begin
        tv_d     = {tv_q[LAT-1:0], hs};
        tl_d     = {tl_q[LAT-1:0], hs & sel_last};
        tch_d[0] = hs ? ptr_q : '0;
        for (int unsigned i = 1; i <= LAT; i++) begin
            tch_d[i] = tch_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFlush;
            cnt_q      <= FlushInit;
            ptr_q      <= PtrInit;
            owner_oh_q <= '0;
            xin_q      <= '0;
            ce_q       <= 1'b0;
            tv_q       <= '0;
            tl_q       <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tch_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            owner_oh_q <= owner_oh_d;
            xin_q      <= xin_d;
            ce_q       <= ce_d;
            tv_q       <= tv_d;
            tl_q       <= tl_d;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tch_q[i] <= tch_d[i];
            end
        end
    end

    assign fir_xin   = xin_q;
    assign fir_ce    = ce_q;
    assign out_valid = tv_q[LAT];
    assign out_last  = tl_q[LAT];
    assign out_ch    = tch_q[LAT];
    assign out_data  = fir_yout;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fir_stream_scheduler.sv
// Directed bench for fir_stream_scheduler with TAPS=4, LAT=1, NCH=4 and a
// clock-enabled 4-tap FIR (h = 1,2,3,4) standing in for the filter instance.
module tb_fir_stream_scheduler;

    localparam int WL   = 32;
    localparam int NCH  = 4;
    localparam int TAPS = 4;
    localparam int LAT  = 1;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_last;
    logic [NCH*WL-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic [WL-1:0]     fir_xin;
    logic              fir_ce;
    logic [WL-1:0]     fir_yout;
    logic              out_valid;
    logic [WL-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic              out_last;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_stream_scheduler #(
        .WL   (WL),
        .NCH  (NCH),
        .TAPS (TAPS),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fir_xin   (fir_xin),
        .fir_ce    (fir_ce),
        .fir_yout  (fir_yout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .busy      (busy)
    );

    // y[n] = x[n] + 2x[n-1] + 3x[n-2] + 4x[n-3], one cycle of latency, shifts only on fir_ce
    logic [WL-1:0] dl0 = '0, dl1 = '0, dl2 = '0;
    logic [WL-1:0] yout_q = '0;
    always @(posedge clk) begin
        if (fir_ce) begin
            yout_q <= fir_xin + 32'd2 * dl0 + 32'd3 * dl1 + 32'd4 * dl2;
            dl0    <= fir_xin;
            dl1    <= dl0;
            dl2    <= dl1;
        end
    end
    assign fir_yout = yout_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Output beat and grant monitors, sampled on the falling edge.
    logic [WL-1:0]  q_data[$];
    logic [CW-1:0]  q_ch[$];
    logic           q_last[$];
    int             grants[$];
    int             multi = 0;
    logic [NCH-1:0] prev_rdy = '0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_data.push_back(out_data);
            q_ch.push_back(out_ch);
            q_last.push_back(out_last);
        end
        if ($countones(req_ready) > 1) multi++;
        if (req_ready != '0 && prev_rdy == '0) begin
            for (int i = 0; i < NCH; i++) if (req_ready[i]) grants.push_back(i);
        end
        prev_rdy = req_ready;
    end

    task automatic clear_mon();
        q_data.delete();
        q_ch.delete();
        q_last.delete();
        grants.delete();
    endtask

    // Sends one packet on channel ch; a 2-cycle valid gap is inserted before sample gap_at.
    task automatic send(input int ch, input int n, input logic [WL-1:0] d0, input logic [WL-1:0] d1,
                        input logic [WL-1:0] d2, input logic [WL-1:0] d3, input int gap_at);
        logic [WL-1:0] d[4];
        int waited;
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                req_valid[ch] = 1'b0;
                @(posedge clk); #1;
                check("gap_ce_a", 32'(fir_ce), 0);
                @(posedge clk); #1;
                check("gap_ce_b", 32'(fir_ce), 0);
            end
            req_valid[ch]            = 1'b1;
            req_data[ch*WL +: WL]    = d[i];
            req_last[ch]             = (i == n - 1);
            waited = 0;
            while (1) begin
                @(negedge clk);
                if (req_ready[ch]) break;
                waited++;
                if (waited > 40) begin
                    check("ready_timeout", 32'(req_ready[ch]), 1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        req_valid[ch] = 1'b0;
        req_last[ch]  = 1'b0;
    endtask

    task automatic expect_beats(input string tag, input int n, input logic [WL-1:0] e0,
                                input logic [WL-1:0] e1, input logic [WL-1:0] e2,
                                input logic [WL-1:0] e3, input int ch, input bit all_last);
        logic [WL-1:0] e[4];
        e = '{e0, e1, e2, e3};
        check({tag, "_count"}, 32'(q_data.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < q_data.size()) begin
                check({tag, "_data"}, q_data[i], e[i]);
                check({tag, "_ch"}, 32'(q_ch[i]), 32'(ch));
                check({tag, "_last"}, 32'(q_last[i]), 32'(all_last || (i == n - 1)));
            end
        end
        clear_mon();
    endtask

    int arb_d[8] = '{1, 4, 5, 16, 1, 4, 5, 16};
    int arb_c[8] = '{0, 0, 3, 3, 0, 0, 3, 3};
    int arb_g[4] = '{0, 3, 0, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;

        // Reset state and release flush
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 1);
        check("rst_ce", 32'(fir_ce), 0);
        check("rst_xin", fir_xin, 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_oval", 32'(out_valid), 0);
        check("rst_och", 32'(out_ch), 0);
        check("rst_olast", 32'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("rel_busy", 32'(busy), 32'(c < 3));
            check("rel_ce", 32'(fir_ce), 32'(c <= 3));
            check("rel_xin", fir_xin, 0);
            check("rel_oval", 32'(out_valid), 0);
        end
        clear_mon();

        // Channel 2 packet then its flush
        send(2, 4, 0, -1, -2, 3, -1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_ce", 32'(fir_ce), 1);
            check("flush_xin", fir_xin, 0);
            check("flush_oval", 32'(out_valid), 32'(i == 0));
        end
        @(negedge clk);
        check("post_flush_ce", 32'(fir_ce), 0);
        check("post_flush_oval", 32'(out_valid), 0);
        expect_beats("ch2", 4, 0, -1, -4, -4, 2, 1'b0);

        // Gapless then gapped packet, same results
        send(1, 4, 3, 4, -5, 1, -1);
        repeat (6) @(posedge clk);
        expect_beats("nogap", 4, 3, 10, 12, 15, 1, 1'b0);
        send(1, 4, 3, 4, -5, 1, 2);
        repeat (6) @(posedge clk);
        expect_beats("gap", 4, 3, 10, 12, 15, 1, 1'b0);

        // Back-to-back single-sample packets
        send(1, 1, 4, 0, 0, 0, -1);
        send(1, 1, -5, 0, 0, 0, -1);
        repeat (6) @(posedge clk);
        expect_beats("single", 2, 4, -5, 0, 0, 1, 1'b1);

        // Two channels contending after reset
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        fork
            begin
                send(0, 2, 1, 2, 0, 0, -1);
                send(0, 2, 1, 2, 0, 0, -1);
            end
            begin
                send(3, 2, 5, 6, 0, 0, -1);
                send(3, 2, 5, 6, 0, 0, -1);
            end
        join
        repeat (6) @(posedge clk);
        check("arb_grants", 32'(grants.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("arb_order", 32'(grants[i]), 32'(arb_g[i]));
        end
        check("arb_onehot", 32'(multi), 0);
        check("arb_beats", 32'(q_data.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_data.size()) begin
                check("arb_data", q_data[i], 32'(arb_d[i]));
                check("arb_ch", 32'(q_ch[i]), 32'(arb_c[i]));
                check("arb_last", 32'(q_last[i]), 32'(i % 2 == 1));
            end
        end
        clear_mon();

        // Reset pulse during channel 0's third sample
        req_data[0 +: WL] = 10;
        req_last[0]       = 1'b0;
        req_valid[0]      = 1'b1;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        check("mid_granted", 32'(req_ready[0]), 1);
        @(posedge clk); #1;
        req_data[0 +: WL] = 11;
        @(posedge clk); #1;
        req_data[0 +: WL] = 12;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ready", 32'(req_ready), 0);
        check("mid_ce", 32'(fir_ce), 0);
        check("mid_oval", 32'(out_valid), 0);
        @(negedge clk);
        rst_n             = 1'b1;
        req_data[0 +: WL] = 10;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("regrant_ready", 32'(req_ready[0]), 32'(c == 4));
        end
        req_last[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        repeat (6) @(posedge clk);
        expect_beats("resend", 1, 10, 0, 0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
